// File: rtl/axppa_err_monitor.sv
// Stimulus and error-metric engine for an adder under test. Two LFSRs drive the operands,
// and the adder's sum is scored against an exact reference delayed by LAT cycles.
module axppa_err_monitor #(
  parameter int          N_LOG2 = 10,
  parameter logic [15:0] SEED_A = 16'hACE1,
  parameter logic [15:0] SEED_B = 16'h1D87,
  parameter int          LAT    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [15:0]         op_a,
  output logic [15:0]         op_b,
  output logic                op_cin,
  input  logic [16:0]         dut_sum,
  output logic [N_LOG2:0]     err_count,
  output logic [16:0]         max_ed,
  output logic [16+N_LOG2:0]  sum_ed
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [15:0] SEED_A_EFF = (SEED_A == 16'h0000) ? 16'h0001 : SEED_A;
  localparam logic [15:0] SEED_B_EFF = (SEED_B == 16'h0000) ? 16'h0001 : SEED_B;
  // Stages 1..LAT-1 of the delay line; once these are empty, the final vector is in the last stage.
  localparam logic [LAT:0] MID_MASK = (LAT+1)'((1 << LAT) - 2);

  state_t              r_state;
  state_t              w_state_next;
  logic                w_load;
  logic                w_advance;
  logic [N_LOG2-1:0]   r_idx;
  logic [15:0]         r_lfsr_a;
  logic [15:0]         r_lfsr_b;
  logic                r_cin;
  logic [15:0]         w_next_a;
  logic [15:0]         w_next_b;
  logic [16:0]         w_exact;
  logic [LAT:0]        w_vld;
  logic [16:0]         w_pipe [0:LAT];
  logic [16:0]         w_exact_d;
  logic [16:0]         w_ed;
  logic [N_LOG2:0]     r_err_count;
  logic [16:0]         r_max_ed;
  logic [16+N_LOG2:0]  r_sum_ed;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
          w_load       = 1'b1;
        end
      end
      S_RUN: begin
        // The last vector stays on the operand outputs after issue.
        if (r_idx == '1) w_state_next = (LAT == 0) ? S_DONE : S_DRAIN;
        else             w_advance    = 1'b1;
      end
      S_DRAIN: begin
        if ((w_vld & MID_MASK) == '0) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_next_a = lfsr_step(r_lfsr_a);
  assign w_next_b = lfsr_step(r_lfsr_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr_a <= '0;
      r_lfsr_b <= '0;
      r_cin    <= 1'b0;
      r_idx    <= '0;
    end else if (w_load) begin
      r_lfsr_a <= SEED_A_EFF;
      r_lfsr_b <= SEED_B_EFF;
      r_cin    <= SEED_A_EFF[15] ^ SEED_B_EFF[15];
      r_idx    <= '0;
    end else if (w_advance) begin
      r_lfsr_a <= w_next_a;
      r_lfsr_b <= w_next_b;
      r_cin    <= w_next_a[15] ^ w_next_b[15];
      r_idx    <= r_idx + N_LOG2'(1);
    end
  end

  assign w_exact = {1'b0, r_lfsr_a} + {1'b0, r_lfsr_b} + {16'h0000, r_cin};

  // Stage 0 is the live vector; stage k carries the reference k cycles later.
  assign w_vld[0]  = (r_state == S_RUN);
  assign w_pipe[0] = w_exact;

  for (genvar gi = 1; gi <= LAT; gi++) begin : g_dly
    logic        r_v;
    logic [16:0] r_d;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= 1'b0;
        r_d <= '0;
      end else begin
        r_v <= w_vld[gi-1];
        r_d <= w_pipe[gi-1];
      end
    end
    assign w_vld[gi]  = r_v;
    assign w_pipe[gi] = r_d;
  end

  assign w_exact_d = w_pipe[LAT];

  always_comb begin
    w_ed = '0;
    if (w_exact_d >= dut_sum) w_ed = w_exact_d - dut_sum;
    else                      w_ed = dut_sum - w_exact_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
      r_max_ed    <= '0;
      r_sum_ed    <= '0;
    end else if (w_load) begin
      r_err_count <= '0;
      r_max_ed    <= '0;
      r_sum_ed    <= '0;
    end else if (w_vld[LAT]) begin
      if (w_ed != 17'd0)     r_err_count <= r_err_count + (N_LOG2+1)'(1);
      if (w_ed > r_max_ed)   r_max_ed    <= w_ed;
      r_sum_ed <= r_sum_ed + {{N_LOG2{1'b0}}, w_ed};
    end
  end

  assign op_a      = r_lfsr_a;
  assign op_b      = r_lfsr_b;
  assign op_cin    = r_cin;
  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign err_count = r_err_count;
  assign max_ed    = r_max_ed;
  assign sum_ed    = r_sum_ed;

endmodule

// File: tb/tb_axppa_err_monitor.sv
// Bench for axppa_err_monitor: three instances (LAT=0, LAT=2, zero seeds), several adder
// behaviours, results scored against a vector-list model of the LFSR sequence.
module tb_axppa_err_monitor;

  logic clk = 1'b0;
  logic rst;
  logic start_req;
  int   sel;
  int   mode;  // 0 exact, 1 lsb flipped, 2 stuck zero, 3 random mask, 5 exact with 2 register stages

  always #5 clk = ~clk;

  logic        start0, start2, startz;
  logic        busy0, busy2, busyz, done0, done2, donez;
  logic [15:0] op_a0, op_a2, op_az, op_b0, op_b2, op_bz;
  logic        op_cin0, op_cin2, op_cinz;
  logic [16:0] dut_sum0, dut_sum2, dut_sumz;
  logic [4:0]  err0, err2, errz;
  logic [16:0] max0, max2, maxz;
  logic [20:0] sum0, sum2, sumz;

  assign start0 = start_req && (sel == 0);
  assign start2 = start_req && (sel == 1);
  assign startz = start_req && (sel == 2);

  axppa_err_monitor #(.N_LOG2(4), .LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .op_a(op_a0), .op_b(op_b0), .op_cin(op_cin0), .dut_sum(dut_sum0),
    .err_count(err0), .max_ed(max0), .sum_ed(sum0));

  axppa_err_monitor #(.N_LOG2(4), .LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .op_a(op_a2), .op_b(op_b2), .op_cin(op_cin2), .dut_sum(dut_sum2),
    .err_count(err2), .max_ed(max2), .sum_ed(sum2));

  axppa_err_monitor #(.N_LOG2(4), .SEED_A(16'h0000), .SEED_B(16'h0000), .LAT(0)) u_dutz (
    .clk(clk), .rst(rst), .start(startz), .busy(busyz), .done(donez),
    .op_a(op_az), .op_b(op_bz), .op_cin(op_cinz), .dut_sum(dut_sumz),
    .err_count(errz), .max_ed(maxz), .sum_ed(sumz));

  // Adder-under-test behaviours
  logic [16:0] rmask [16];
  logic [16:0] ex0, ex2, exz, p1, p2;

  function automatic logic [16:0] resp(input logic [16:0] ex, input logic [16:0] msk, input int md);
    case (md)
      1:       return ex ^ 17'h00001;
      2:       return 17'h00000;
      3:       return ex ^ msk;
      default: return ex;
    endcase
  endfunction

  always_comb begin
    ex0      = 17'(op_a0) + 17'(op_b0) + 17'(op_cin0);
    ex2      = 17'(op_a2) + 17'(op_b2) + 17'(op_cin2);
    exz      = 17'(op_az) + 17'(op_bz) + 17'(op_cinz);
    dut_sum0 = resp(ex0, rmask[op_a0[3:0]], mode);
    dut_sumz = resp(exz, rmask[op_az[3:0]], mode);
    dut_sum2 = (mode == 5) ? p2 : resp(ex2, rmask[op_a2[3:0]], mode);
  end

  always @(posedge clk) begin
    p1 <= ex2;
    p2 <= p1;
  end

  logic        tb_busy, tb_done, tb_op_cin;
  logic [15:0] tb_op_a, tb_op_b;
  logic [4:0]  tb_err;
  logic [16:0] tb_max;
  logic [20:0] tb_sum;

  always_comb begin
    tb_busy = busy0; tb_done = done0; tb_op_a = op_a0; tb_op_b = op_b0; tb_op_cin = op_cin0;
    tb_err = err0; tb_max = max0; tb_sum = sum0;
    if (sel == 1) begin
      tb_busy = busy2; tb_done = done2; tb_op_a = op_a2; tb_op_b = op_b2; tb_op_cin = op_cin2;
      tb_err = err2; tb_max = max2; tb_sum = sum2;
    end else if (sel == 2) begin
      tb_busy = busyz; tb_done = donez; tb_op_a = op_az; tb_op_b = op_bz; tb_op_cin = op_cinz;
      tb_err = errz; tb_max = maxz; tb_sum = sumz;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: vector list from the seeds, then metrics over that list
  int mv_a [16];
  int mv_b [16];
  int mv_c [16];
  int mv_ex[16];

  task automatic model(input int seed_a, input int seed_b, input int lat, input int md,
                       output logic [4:0] er, output logic [16:0] mx, output logic [20:0] sm);
    int sa, sb, j, ed, e, m;
    longint s;
    logic [16:0] r;
    sa = (seed_a == 0) ? 1 : seed_a;
    sb = (seed_b == 0) ? 1 : seed_b;
    for (int i = 0; i < 16; i++) begin
      mv_a[i]  = sa;
      mv_b[i]  = sb;
      mv_c[i]  = ((sa >> 15) ^ (sb >> 15)) & 1;
      mv_ex[i] = sa + sb + mv_c[i];
      sa = (sa >> 1) | ((((sa) ^ (sa >> 2) ^ (sa >> 3) ^ (sa >> 5)) & 1) << 15);
      sb = (sb >> 1) | ((((sb) ^ (sb >> 2) ^ (sb >> 3) ^ (sb >> 5)) & 1) << 15);
    end
    e = 0; m = 0; s = 0;
    for (int i = 0; i < 16; i++) begin
      // A combinational adder behind a LAT-deep reference sees the vector LAT steps ahead.
      j  = (md == 5) ? i : ((i + lat > 15) ? 15 : i + lat);
      r  = resp(17'(mv_ex[j]), rmask[mv_a[j] & 15], md);
      ed = (mv_ex[i] > int'(r)) ? mv_ex[i] - int'(r) : int'(r) - mv_ex[i];
      if (ed != 0) e++;
      if (ed > m)  m = ed;
      s += ed;
    end
    er = 5'(e); mx = 17'(m); sm = 21'(s);
  endtask

  task automatic do_run(input int restart_at, output int busy_cyc, output int done_cyc,
                        output int done_cnt, output logic [15:0] a0, output logic [15:0] b0,
                        output logic c0, output logic [15:0] a1, output logic [4:0] er,
                        output logic [16:0] mx, output logic [20:0] sm);
    busy_cyc = 0; done_cyc = -1; done_cnt = 0; a1 = '0; er = '0; mx = '0; sm = '0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1 start_req = 1'b1;
    @(posedge clk);
    #1 start_req = 1'b0;
    a0 = tb_op_a; b0 = tb_op_b; c0 = tb_op_cin;
    if (tb_busy) busy_cyc++;
    for (int k = 1; k < 40; k++) begin
      start_req = (k == restart_at);
      @(posedge clk);
      #1;
      if (k == 1) a1 = tb_op_a;
      if (tb_busy) busy_cyc++;
      if (tb_done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = k; er = tb_err; mx = tb_max; sm = tb_sum;
        end
      end
    end
    start_req = 1'b0;
    $display("run sel=%0d mode=%0d busy=%0d done_at=%0d pulses=%0d err=%0d max=%0d sum=%0d",
             sel, mode, busy_cyc, done_cyc, done_cnt, er, mx, sm);
  endtask

  int          bc, dc, dn;
  logic [15:0] a0, b0, a1;
  logic        c0;
  logic [4:0]  er, xer;
  logic [16:0] mx, xmx;
  logic [20:0] sm, xsm;

  task automatic test_reset();
    rst = 1'b1; start_req = 1'b0; sel = 0; mode = 0;
    for (int i = 0; i < 16; i++) rmask[i] = '0;
    #3;
    n_checks++; if ({busy0, done0, op_a0, op_b0, op_cin0} !== 35'd0) $display("FAIL reset_ctl0: got %h want 0", {busy0, done0, op_a0, op_b0, op_cin0}); else n_pass++;
    n_checks++; if ({err0, max0, sum0} !== 43'd0) $display("FAIL reset_acc0: got %h want 0", {err0, max0, sum0}); else n_pass++;
    n_checks++; if ({busy2, done2, op_a2, err2, max2, sum2} !== 61'd0) $display("FAIL reset_dut2: got %h want 0", {busy2, done2, op_a2, err2, max2, sum2}); else n_pass++;
    n_checks++; if ({busyz, donez, op_az, op_bz, errz, sumz} !== 60'd0) $display("FAIL reset_dutz: got %h want 0", {busyz, donez, op_az, op_bz, errz, sumz}); else n_pass++;
    #9 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_exact_first();
    sel = 0; mode = 0;
    model(16'hACE1, 16'h1D87, 0, 0, xer, xmx, xsm);
    do_run(-1, bc, dc, dn, a0, b0, c0, a1, er, mx, sm);
    n_checks++; if (a0 !== 16'hACE1) $display("FAIL first_op_a: got %h want ace1", a0); else n_pass++;
    n_checks++; if (b0 !== 16'h1D87) $display("FAIL first_op_b: got %h want 1d87", b0); else n_pass++;
    n_checks++; if (c0 !== 1'b1) $display("FAIL first_cin: got %b want 1", c0); else n_pass++;
    n_checks++; if (a1 !== 16'h5670) $display("FAIL second_op_a: got %h want 5670", a1); else n_pass++;
    n_checks++; if (bc != 16) $display("FAIL busy_len: got %0d want 16", bc); else n_pass++;
    n_checks++; if (dc != 16 || dn != 1) $display("FAIL done_pulse: got at %0d x%0d want at 16 x1", dc, dn); else n_pass++;
    n_checks++; if ({er, mx, sm} !== 43'd0) $display("FAIL exact_metrics: got %0d/%0d/%0d want 0/0/0", er, mx, sm); else n_pass++;
    n_checks++; if (tb_op_a !== 16'(mv_a[15])) $display("FAIL op_hold: got %h want %h", tb_op_a, 16'(mv_a[15])); else n_pass++;
  endtask

  task automatic test_single_bit();
    sel = 0; mode = 1;
    model(16'hACE1, 16'h1D87, 0, 1, xer, xmx, xsm);
    do_run(-1, bc, dc, dn, a0, b0, c0, a1, er, mx, sm);
    n_checks++; if (er !== 5'd16 || mx !== 17'd1 || sm !== 21'd16) $display("FAIL lsb_err: got %0d/%0d/%0d want 16/1/16", er, mx, sm); else n_pass++;
    n_checks++; if (tb_err !== xer || tb_sum !== xsm) $display("FAIL lsb_hold: got %0d/%0d want %0d/%0d", tb_err, tb_sum, xer, xsm); else n_pass++;
  endtask

  task automatic test_pipelined();
    sel = 1; mode = 5;
    do_run(-1, bc, dc, dn, a0, b0, c0, a1, er, mx, sm);
    n_checks++; if (bc != 18 || dc != 18 || dn != 1) $display("FAIL lat2_timing: got busy %0d done %0d x%0d want 18/18 x1", bc, dc, dn); else n_pass++;
    n_checks++; if ({er, mx, sm} !== 43'd0) $display("FAIL lat2_exact: got %0d/%0d/%0d want 0/0/0", er, mx, sm); else n_pass++;
    mode = 0;
    model(16'hACE1, 16'h1D87, 2, 0, xer, xmx, xsm);
    do_run(-1, bc, dc, dn, a0, b0, c0, a1, er, mx, sm);
    n_checks++; if (er === 5'd0) $display("FAIL lat2_comb_nonzero: got %0d want nonzero", er); else n_pass++;
    n_checks++; if (er !== xer || mx !== xmx || sm !== xsm) $display("FAIL lat2_comb: got %0d/%0d/%0d want %0d/%0d/%0d", er, mx, sm, xer, xmx, xsm); else n_pass++;
  endtask

  task automatic test_stuck_zero();
    int big;
    longint tot;
    sel = 0; mode = 2;
    model(16'hACE1, 16'h1D87, 0, 2, xer, xmx, xsm);
    big = 0; tot = 0;
    for (int i = 0; i < 16; i++) begin
      if (mv_ex[i] > big) big = mv_ex[i];
      tot += mv_ex[i];
    end
    do_run(-1, bc, dc, dn, a0, b0, c0, a1, er, mx, sm);
    n_checks++; if (mx !== 17'(big)) $display("FAIL stuck_max: got %0d want %0d", mx, big); else n_pass++;
    n_checks++; if (sm !== 21'(tot)) $display("FAIL stuck_sum: got %0d want %0d", sm, tot); else n_pass++;
    n_checks++; if (er !== xer) $display("FAIL stuck_err: got %0d want %0d", er, xer); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    sel = 0; mode = 1;
    do_run(5, bc, dc, dn, a0, b0, c0, a1, er, mx, sm);
    n_checks++; if (bc != 16 || dc != 16 || dn != 1) $display("FAIL restart_timing: got busy %0d done %0d x%0d want 16/16 x1", bc, dc, dn); else n_pass++;
    n_checks++; if (er !== 5'd16 || sm !== 21'd16) $display("FAIL restart_counts: got %0d/%0d want 16/16", er, sm); else n_pass++;
  endtask

  task automatic test_back_to_back();
    sel = 0; mode = 0;
    do_run(17, bc, dc, dn, a0, b0, c0, a1, er, mx, sm);
    n_checks++; if (bc != 16 || dn != 1) $display("FAIL done_start_ignored: got busy %0d pulses %0d want 16 x1", bc, dn); else n_pass++;
    do_run(-1, bc, dc, dn, a0, b0, c0, a1, er, mx, sm);
    n_checks++; if (a0 !== 16'hACE1 || dc != 16) $display("FAIL next_run: got %h at %0d want ace1 at 16", a0, dc); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int dseen, bseen;
    sel = 0; mode = 1;
    start_req = 1'b1;
    @(posedge clk);
    #1 start_req = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({busy0, done0, op_a0, op_b0, op_cin0} !== 35'd0) $display("FAIL midrst_ctl: got %h want 0", {busy0, done0, op_a0, op_b0, op_cin0}); else n_pass++;
    n_checks++; if ({err0, max0, sum0} !== 43'd0) $display("FAIL midrst_acc: got %h want 0", {err0, max0, sum0}); else n_pass++;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    dseen = 0; bseen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done0) dseen++;
      if (busy0) bseen++;
    end
    n_checks++; if (dseen != 0 || bseen != 0) $display("FAIL midrst_nodone: got done %0d busy %0d want 0/0", dseen, bseen); else n_pass++;
    mode = 0;
    do_run(-1, bc, dc, dn, a0, b0, c0, a1, er, mx, sm);
    n_checks++; if (a0 !== 16'hACE1 || b0 !== 16'h1D87 || c0 !== 1'b1 || a1 !== 16'h5670) $display("FAIL midrst_rerun_ops: got %h %h %b %h", a0, b0, c0, a1); else n_pass++;
    n_checks++; if (bc != 16 || dc != 16 || {er, mx, sm} !== 43'd0) $display("FAIL midrst_rerun: got busy %0d done %0d res %0d/%0d/%0d", bc, dc, er, mx, sm); else n_pass++;
  endtask

  task automatic test_zero_seeds();
    sel = 2; mode = 0;
    model(0, 0, 0, 0, xer, xmx, xsm);
    do_run(-1, bc, dc, dn, a0, b0, c0, a1, er, mx, sm);
    n_checks++; if (a0 !== 16'h0001 || b0 !== 16'h0001 || c0 !== 1'b0) $display("FAIL zero_seed_first: got %h %h %b want 0001 0001 0", a0, b0, c0); else n_pass++;
    n_checks++; if (a1 !== 16'(mv_a[1])) $display("FAIL zero_seed_second: got %h want %h", a1, 16'(mv_a[1])); else n_pass++;
    n_checks++; if (dc != 16 || er !== 5'd0) $display("FAIL zero_seed_run: got done %0d err %0d want 16/0", dc, er); else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      sel = it % 2; mode = 3;
      for (int i = 0; i < 16; i++) rmask[i] = ($urandom_range(0, 1) == 0) ? 17'h0 : 17'($urandom);
      model(16'hACE1, 16'h1D87, (sel == 1) ? 2 : 0, 3, xer, xmx, xsm);
      do_run(-1, bc, dc, dn, a0, b0, c0, a1, er, mx, sm);
      n_checks++; if (er !== xer || mx !== xmx || sm !== xsm) $display("FAIL random_%0d: got %0d/%0d/%0d want %0d/%0d/%0d", it, er, mx, sm, xer, xmx, xsm); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_exact_first();
    test_single_bit();
    test_pipelined();
    test_stuck_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_zero_seeds();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
